// File: rtl/multi_data_sync_pkg.sv
// Shared constants and helpers for the multi-channel data synchronizer.
// Event-mode encodings and channel slice arithmetic live here.
package multi_data_sync_pkg;

    localparam int EVENT_LEVEL  = 0;
    localparam int EVENT_TOGGLE = 1;

    function automatic int ch_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/multi_data_sync_channel.sv
// One synchronizer channel: enable chain, edge detect, capture register,
// valid/ready output handshake, sticky overrun and ack toggle.
module sync_channel
    import multi_data_sync_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8,
    parameter int EVENT_MODE = EVENT_LEVEL
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [BUS_WIDTH-1:0] data_i,
    input  logic                 enable_i,
    input  logic                 ready_i,
    input  logic                 ovr_clr_i,
    output logic [BUS_WIDTH-1:0] data_o,
    output logic                 valid_o,
    output logic                 pulse_o,
    output logic                 ack_o,
    output logic                 ovr_o
);

    logic [NUM_STAGES-1:0] chain_q, chain_d;
    logic                  prev_q, prev_d;
    logic [BUS_WIDTH-1:0]  data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  pulse_q, pulse_d;
    logic                  ack_q, ack_d;
    logic                  ovr_q, ovr_d;

    logic chain_out;
    logic evt;
    logic xfer;
    logic capture;
    logic drop;

    always_comb begin
        chain_d   = {chain_q[NUM_STAGES-2:0], enable_i};
        chain_out = chain_q[NUM_STAGES-1];
        prev_d    = chain_out;
        evt       = (EVENT_MODE == EVENT_TOGGLE) ? (chain_out ^ prev_q)
                                                 : (chain_out & ~prev_q);
        xfer      = valid_q & ready_i;
        // A pending word may be replaced only in the cycle it is consumed
        capture   = evt & (~valid_q | ready_i);
        drop      = evt & valid_q & ~ready_i;
        data_d    = capture ? data_i : data_q;
        valid_d   = capture | (valid_q & ~ready_i);
        pulse_d   = capture;
        ack_d     = ack_q ^ xfer;
        ovr_d     = drop | (ovr_q & ~ovr_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
            ack_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            pulse_q <= pulse_d;
            ack_q   <= ack_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign pulse_o = pulse_q;
    assign ack_o   = ack_q;
    assign ovr_o   = ovr_q;

endmodule

// File: rtl/multi_data_sync.sv
// Multi-channel enable-qualified data synchronizer into the CLK domain.
// Channels are independent; this level only slices and packs the buses.
module multi_data_sync
    import multi_data_sync_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_CH     = 4,
    parameter int EVENT_MODE = EVENT_LEVEL
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_CH*BUS_WIDTH-1:0] Unsync_bus,
    input  logic [NUM_CH-1:0]           bus_enable,
    output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
    output logic [NUM_CH-1:0]           sync_valid,
    input  logic [NUM_CH-1:0]           sync_ready,
    output logic [NUM_CH-1:0]           enable_pulse,
    output logic [NUM_CH-1:0]           ack_toggle,
    output logic [NUM_CH-1:0]           overrun,
    input  logic                        overrun_clr
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam int LSB = ch_lsb(c, BUS_WIDTH);

        sync_channel #(
            .NUM_STAGES (NUM_STAGES),
            .BUS_WIDTH  (BUS_WIDTH),
            .EVENT_MODE (EVENT_MODE)
        ) u_ch (
            .clk_i     (CLK),
            .rst_i     (RST),
            .data_i    (Unsync_bus[LSB +: BUS_WIDTH]),
            .enable_i  (bus_enable[c]),
            .ready_i   (sync_ready[c]),
            .ovr_clr_i (overrun_clr),
            .data_o    (sync_bus[LSB +: BUS_WIDTH]),
            .valid_o   (sync_valid[c]),
            .pulse_o   (enable_pulse[c]),
            .ack_o     (ack_toggle[c]),
            .ovr_o     (overrun[c])
        );
    end

endmodule

// File: tb/tb_multi_data_sync.sv
// Directed bench: level-mode and toggle-mode instances share stimulus.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_multi_data_sync;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] Unsync_bus;
    logic [3:0]  bus_enable;
    logic [3:0]  sync_ready;
    logic        overrun_clr;

    logic [31:0] sync_bus,     t_sync_bus;
    logic [3:0]  sync_valid,   t_sync_valid;
    logic [3:0]  enable_pulse, t_enable_pulse;
    logic [3:0]  ack_toggle,   t_ack_toggle;
    logic [3:0]  overrun,      t_overrun;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    multi_data_sync #(
        .NUM_STAGES(2), .BUS_WIDTH(8), .NUM_CH(4), .EVENT_MODE(0)
    ) u_dut (
        .CLK          (CLK),
        .RST          (RST),
        .Unsync_bus   (Unsync_bus),
        .bus_enable   (bus_enable),
        .sync_bus     (sync_bus),
        .sync_valid   (sync_valid),
        .sync_ready   (sync_ready),
        .enable_pulse (enable_pulse),
        .ack_toggle   (ack_toggle),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    multi_data_sync #(
        .NUM_STAGES(2), .BUS_WIDTH(8), .NUM_CH(4), .EVENT_MODE(1)
    ) u_dut_t (
        .CLK          (CLK),
        .RST          (RST),
        .Unsync_bus   (Unsync_bus),
        .bus_enable   (bus_enable),
        .sync_bus     (t_sync_bus),
        .sync_valid   (t_sync_valid),
        .sync_ready   (sync_ready),
        .enable_pulse (t_enable_pulse),
        .ack_toggle   (t_ack_toggle),
        .overrun      (t_overrun),
        .overrun_clr  (overrun_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        logic [3:0]  seen;
        logic [7:0]  tv [3];
        int          npulse;

        tv[0] = 8'h11;
        tv[1] = 8'h22;
        tv[2] = 8'h33;

        // Reset and idle
        RST         = 1'b1;
        Unsync_bus  = '0;
        bus_enable  = '0;
        sync_ready  = '0;
        overrun_clr = 1'b0;
        tick(2);
        chk("rst_bus",   sync_bus,       32'h0);
        chk("rst_valid", {28'h0, sync_valid},   32'h0);
        chk("rst_pulse", {28'h0, enable_pulse}, 32'h0);
        chk("rst_ack",   {28'h0, ack_toggle},   32'h0);
        chk("rst_ovr",   {28'h0, overrun},      32'h0);
        chk("rst_t_all", {t_sync_bus[3:0], t_sync_valid, t_enable_pulse,
                          t_ack_toggle, t_overrun}, 32'h0);
        RST = 1'b0;
        seen = '0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            seen = seen | enable_pulse | t_enable_pulse;
        end
        chk("idle_pulse", {28'h0, seen}, 32'h0);

        // Level mode, ch0: capture latency, pulse width, accept
        Unsync_bus[7:0] = 8'hA5;
        bus_enable[0]   = 1'b1;
        tick(2);
        chk("lvl_early_valid", {31'h0, sync_valid[0]}, 32'h0);
        tick(1);
        chk("lvl_bus",   {24'h0, sync_bus[7:0]},   32'hA5);
        chk("lvl_valid", {31'h0, sync_valid[0]},   32'h1);
        chk("lvl_pulse", {31'h0, enable_pulse[0]}, 32'h1);
        tick(1);
        chk("lvl_pulse_w", {31'h0, enable_pulse[0]}, 32'h0);
        chk("lvl_hold",    {31'h0, sync_valid[0]},   32'h1);
        tick(1);
        sync_ready[0] = 1'b1;
        tick(1);
        sync_ready[0] = 1'b0;
        chk("lvl_clr_valid", {31'h0, sync_valid[0]}, 32'h0);
        chk("lvl_ack",       {31'h0, ack_toggle[0]}, 32'h1);

        // Toggle mode, ch1: three edges, each accepted immediately
        sync_ready[1] = 1'b1;
        npulse = 0;
        for (int k = 0; k < 3; k++) begin
            Unsync_bus[15:8] = tv[k];
            bus_enable[1]    = ~bus_enable[1];
            tick(3);
            chk("tgl_bus", {24'h0, t_sync_bus[15:8]}, {24'h0, tv[k]});
            if (t_enable_pulse[1]) npulse++;
            tick(1);
            chk("tgl_pulse_w", {31'h0, t_enable_pulse[1]}, 32'h0);
            chk("tgl_valid",   {31'h0, t_sync_valid[1]},   32'h0);
        end
        chk("tgl_npulse", npulse, 3);
        chk("tgl_ack",    {31'h0, t_ack_toggle[1]}, 32'h1);
        chk("tgl_ovr",    {31'h0, t_overrun[1]},    32'h0);

        // Overrun, ch2 (level instance)
        Unsync_bus[23:16] = 8'h3C;
        bus_enable[2]     = 1'b1;
        tick(3);
        chk("ovr_first", {24'h0, sync_bus[23:16]}, 32'h3C);
        bus_enable[2] = 1'b0;
        tick(3);
        Unsync_bus[23:16] = 8'hC3;
        bus_enable[2]     = 1'b1;
        tick(3);
        chk("ovr_keep",  {24'h0, sync_bus[23:16]}, 32'h3C);
        chk("ovr_set",   {31'h0, overrun[2]},      32'h1);
        chk("ovr_nopls", {31'h0, enable_pulse[2]}, 32'h0);
        bus_enable[2] = 1'b0;
        tick(3);
        bus_enable[2] = 1'b1;
        tick(2);
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        chk("ovr_set_wins", {31'h0, overrun[2]}, 32'h1);
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        chk("ovr_clr", {28'h0, overrun}, 32'h0);

        // Back-to-back accept, ch3
        Unsync_bus[31:24] = 8'h5A;
        bus_enable[3]     = 1'b1;
        tick(3);
        chk("b2b_first", {24'h0, sync_bus[31:24]}, 32'h5A);
        bus_enable[3] = 1'b0;
        tick(3);
        Unsync_bus[31:24] = 8'h6B;
        bus_enable[3]     = 1'b1;
        tick(2);
        sync_ready[3] = 1'b1;
        tick(1);
        sync_ready[3] = 1'b0;
        chk("b2b_bus",   {24'h0, sync_bus[31:24]}, 32'h6B);
        chk("b2b_valid", {31'h0, sync_valid[3]},   32'h1);
        chk("b2b_pulse", {31'h0, enable_pulse[3]}, 32'h1);
        chk("b2b_ack",   {31'h0, ack_toggle[3]},   32'h1);
        chk("b2b_ovr",   {31'h0, overrun[3]},      32'h0);

        // Reset mid-operation with all enables still high
        sync_ready = '0;
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        chk("mrst_bus",   sync_bus, 32'h0);
        chk("mrst_misc",  {16'h0, sync_valid, enable_pulse, ack_toggle,
                           overrun}, 32'h0);
        tick(2);
        chk("mrst_early", {28'h0, sync_valid}, 32'h0);
        tick(1);
        chk("mrst_bus2",   sync_bus,              32'h6BC333A5);
        chk("mrst_valid",  {28'h0, sync_valid},   32'hF);
        chk("mrst_pulse",  {28'h0, enable_pulse}, 32'hF);
        chk("mrst_tpulse", {28'h0, t_enable_pulse}, 32'hF);
        tick(1);
        chk("mrst_pulse_w", {28'h0, enable_pulse}, 32'h0);
        chk("mrst_hold",    {28'h0, sync_valid},   32'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
